// File: rtl/acc_requant_out_pkg.sv
// rtl/acc_requant_out_pkg.sv - shared constants and helpers for accumulator requantization
package acc_requant_out_pkg;

  localparam int SAT_CNT_W = 16;

  // Saturation bounds of a w-bit two's complement value
  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  // Half-LSB added before the arithmetic shift: round half toward +inf
  function automatic longint rnd_const(input int f);
    return (f > 0) ? (longint'(1) <<< (f - 1)) : longint'(0);
  endfunction

  // FIFO entry is {last, data[w-1:0]}
  function automatic int entry_w(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/acc_requant_out_fifo2.sv
// rtl/acc_requant_out_fifo2.sv - two-entry register FIFO with valid/ready on both sides
module requant_fifo2
  import acc_requant_out_pkg::*;
#(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         s_tvalid,
  output logic         s_tready,
  input  logic [W-1:0] s_tdata,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic [W-1:0] m_tdata
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign m_tvalid = (count != 2'd0);
  // A full FIFO still takes a beat when the head leaves in the same cycle
  assign s_tready = (count != 2'd2) || m_tready;
  assign pop      = m_tvalid && m_tready;
  assign push     = s_tvalid && s_tready;
  assign m_tdata  = m_tvalid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= s_tdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/acc_requant_out.sv
// rtl/acc_requant_out.sv - round/shift/saturate/ReLU of 2n-bit sums onto an n-bit output stream
module acc_requant_out
  import acc_requant_out_pkg::*;
#(
  parameter int n       = 16,
  parameter int frac    = 8,
  parameter int NEURONS = 8,
  parameter bit RELU_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 acc_valid,
  output logic                 acc_ready,
  input  logic [2*n-1:0]       acc_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [n-1:0]         out_data,
  output logic                 out_last,
  output logic [SAT_CNT_W-1:0] sat_count
);

  localparam int AW = 2 * n + 1;
  localparam int EW = entry_w(n);
  localparam int CW = (NEURONS > 1) ? $clog2(NEURONS) : 1;
  localparam logic signed [AW-1:0] RND  = AW'(rnd_const(frac));
  localparam logic signed [AW-1:0] SMAX = AW'(sat_max(n));
  localparam logic signed [AW-1:0] SMIN = AW'(sat_min(n));
  localparam logic [CW-1:0] LAST_IDX = CW'(NEURONS - 1);

  logic                 s1_valid;
  logic signed [AW-1:0] s1_r;
  logic signed [AW-1:0] acc_ext;
  logic signed [AW-1:0] r_next;
  logic                 s1_adv;
  logic                 fifo_ready;
  logic                 take;
  logic [n-1:0]         res;
  logic                 clamp;
  logic [CW-1:0]        cnt;
  logic [EW-1:0]        fifo_out;

  // One extra bit of headroom keeps the rounding add from overflowing
  assign acc_ext = AW'(signed'(acc_data));
  assign r_next  = (acc_ext + RND) >>> frac;

  assign s1_adv    = s1_valid && fifo_ready;
  assign acc_ready = !clear && (!s1_valid || s1_adv);
  assign take      = acc_valid && acc_ready;

  always_comb begin
    clamp = 1'b0;
    res   = s1_r[n-1:0];
    if (s1_r > SMAX) begin
      res   = SMAX[n-1:0];
      clamp = 1'b1;
    end else if (s1_r < SMIN) begin
      res   = SMIN[n-1:0];
      clamp = 1'b1;
    end
    // ReLU applies after saturation and is not a saturation event
    if (RELU_EN && res[n-1]) res = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_r     <= '0;
    end else if (clear) begin
      s1_valid <= 1'b0;
    end else if (take) begin
      s1_valid <= 1'b1;
      s1_r     <= r_next;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      sat_count <= '0;
    end else if (clear) begin
      cnt       <= '0;
      sat_count <= '0;
    end else if (s1_adv) begin
      cnt <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
      if (clamp && (sat_count != '1)) sat_count <= sat_count + 1'b1;
    end
  end

  requant_fifo2 #(.W(EW)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (clear),
    .s_tvalid (s1_valid),
    .s_tready (fifo_ready),
    .s_tdata  ({cnt == LAST_IDX, res}),
    .m_tvalid (out_valid),
    .m_tready (out_ready),
    .m_tdata  (fifo_out)
  );

  assign out_last = fifo_out[n];
  assign out_data = fifo_out[n-1:0];

endmodule
